// File: rtl/regfile_mp.sv
// Multi-ported integer register file with forwarding and a
// post-halt register dump stream (valid/ready).
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int IDXW  = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*IDXW-1:0]  rs_num,
  output logic [NRD*XLEN-1:0]  rs_data,
  input  logic [NWR*IDXW-1:0]  rd_num,
  input  logic [NWR*XLEN-1:0]  rd_data,
  input  logic [NWR-1:0]       rd_we,
  input  logic                 halted,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [IDXW-1:0]      dump_idx,
  output logic [XLEN-1:0]      dump_data,
  output logic                 dump_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DUMP,
    S_DONE,
    S_WAIT
  } state_t;

  logic [XLEN-1:0] regs [NREGS];
  logic [IDXW-1:0] wnum [NWR];
  logic [XLEN-1:0] wdata [NWR];

  state_t          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            halted_q;
  logic            trig;

  for (genvar j = 0; j < NWR; j++) begin : g_wr
    assign wnum[j]  = rd_num[j*IDXW +: IDXW];
    assign wdata[j] = rd_data[j*XLEN +: XLEN];
  end

  // Later ports overwrite earlier ones, so the highest port wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (rd_we[j] && wnum[j] != '0) begin
          regs[wnum[j]] <= wdata[j];
        end
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [IDXW-1:0] rnum;
    logic [XLEN-1:0] rv;
    assign rnum = rs_num[k*IDXW +: IDXW];
    always_comb begin
      rv = regs[rnum];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (rd_we[j] && wnum[j] == rnum) begin
            rv = wdata[j];
          end
        end
      end
      if (rst || rnum == '0) begin
        rv = '0;
      end
    end
    assign rs_data[k*XLEN +: XLEN] = rv;
  end

  assign trig = halted & ~halted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      halted_q <= halted;
    end
  end

  // Dump data bypasses the forwarding path: it shows stored contents.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    dump_valid = 1'b0;
    dump_idx   = '0;
    dump_data  = '0;
    dump_done  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_DUMP;
          ptr_d   = '0;
        end
      end
      S_DUMP: begin
        dump_valid = 1'b1;
        dump_idx   = ptr_q;
        dump_data  = regs[ptr_q];
        if (dump_ready) begin
          if (ptr_q == IDXW'(NREGS - 1)) begin
            state_d = S_DONE;
          end else begin
            ptr_d = ptr_q + IDXW'(1);
          end
        end
      end
      S_DONE: begin
        dump_done = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (!halted) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: read/forwarding checks
// and dump-stream beats are queued by stimulus, checked by a monitor.
module tb_regfile_mp;

  localparam int IW = 5;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [31:0]   data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2*IW-1:0] rs_num_a;
  logic [63:0]     rs_data_a;
  logic [2*IW-1:0] rd_num_a;
  logic [63:0]     rd_data_a;
  logic [1:0]      rd_we_a;
  logic            halted_a;
  logic            dv_a, dr_a, dn_a;
  logic [IW-1:0]   di_a;
  logic [31:0]     dd_a;

  logic [2*IW-1:0] rs_num_b;
  logic [63:0]     rs_data_b;
  logic [IW-1:0]   rd_num_b;
  logic [31:0]     rd_data_b;
  logic [0:0]      rd_we_b;
  logic            halted_b;
  logic            dv_b, dr_b, dn_b;
  logic [IW-1:0]   di_b;
  logic [31:0]     dd_b;

  regfile_mp #(
    .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)
  ) u_a (
    .clk(clk), .rst(rst),
    .rs_num(rs_num_a), .rs_data(rs_data_a),
    .rd_num(rd_num_a), .rd_data(rd_data_a), .rd_we(rd_we_a),
    .halted(halted_a),
    .dump_valid(dv_a), .dump_ready(dr_a),
    .dump_idx(di_a), .dump_data(dd_a), .dump_done(dn_a)
  );

  regfile_mp #(
    .XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0)
  ) u_b (
    .clk(clk), .rst(rst),
    .rs_num(rs_num_b), .rs_data(rs_data_b),
    .rd_num(rd_num_b), .rd_data(rd_data_b), .rd_we(rd_we_b),
    .halted(halted_b),
    .dump_valid(dv_b), .dump_ready(dr_b),
    .dump_idx(di_b), .dump_data(dd_b), .dump_done(dn_b)
  );

  int    chk_cnt = 0;
  int    err_cnt = 0;
  int    beat_cnt = 0;
  int    done_cnt = 0;
  int    sel_q[$];
  logic [31:0] exp_q[$];
  string nm_q[$];
  beat_t beat_q[$];

  logic          pv = 1'b0, pr = 1'b0, pdn = 1'b0;
  logic [IW-1:0] pidx = '0;
  logic [31:0]   pdata = '0;

  function automatic logic [31:0] sample(int sel);
    case (sel)
      0: return rs_data_a[31:0];
      1: return rs_data_a[63:32];
      2: return rs_data_b[31:0];
      3: return {31'b0, dv_a};
      4: return {31'b0, dn_a};
      5: return {27'b0, di_a};
      default: return dd_a;
    endcase
  endfunction

  task automatic expect_chk(int sel, logic [31:0] e, string nm);
    sel_q.push_back(sel);
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic push_dump(logic zero);
    for (int i = 0; i < 32; i++) begin
      beat_t b;
      b.idx  = IW'(i);
      b.data = (zero || i == 0) ? 32'h0 : 32'h100 + 32'(i);
      beat_q.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sel_q.size() > 0) begin
      int          s;
      logic [31:0] e, a;
      string       n;
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      a = sample(s);
      chk_cnt++;
      if (a !== e) begin
        err_cnt++;
        $display("FAIL %s: got %h expected %h", n, a, e);
      end
    end
    if (dv_a) begin
      if (pv && !pr) begin
        chk_cnt++;
        if (di_a !== pidx || dd_a !== pdata) begin
          err_cnt++;
          $display("FAIL stall_stable: got %0d/%h expected %0d/%h",
                   di_a, dd_a, pidx, pdata);
        end
      end
      if (dr_a) begin
        chk_cnt++;
        beat_cnt++;
        if (beat_q.size() == 0) begin
          err_cnt++;
          $display("FAIL extra_beat: got idx %0d data %h expected none",
                   di_a, dd_a);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          if (di_a !== b.idx || dd_a !== b.data) begin
            err_cnt++;
            $display("FAIL beat: got %0d/%h expected %0d/%h",
                     di_a, dd_a, b.idx, b.data);
          end
        end
      end
    end else begin
      chk_cnt++;
      if (di_a !== '0 || dd_a !== '0) begin
        err_cnt++;
        $display("FAIL idle_zero: got %0d/%h expected 0/0", di_a, dd_a);
      end
    end
    if (dn_a) begin
      chk_cnt++;
      done_cnt++;
      if (beat_q.size() != 0 || dv_a || pdn) begin
        err_cnt++;
        $display("FAIL done_pulse: got left=%0d valid=%b prev=%b expected 0/0/0",
                 beat_q.size(), dv_a, pdn);
      end
    end
    pv    = dv_a;
    pr    = dr_a;
    pidx  = di_a;
    pdata = dd_a;
    pdn   = dn_a;
  end

  initial begin
    int base;
    int n;
    rs_num_a = '0; rd_num_a = '0; rd_data_a = '0; rd_we_a = '0;
    halted_a = 1'b0; dr_a = 1'b0;
    rs_num_b = '0; rd_num_b = '0; rd_data_b = '0; rd_we_b = '0;
    halted_b = 1'b0; dr_b = 1'b0;
    tick();
    tick();
    rd_we_a   = 2'b01;
    rd_num_a  = {5'd0, 5'd5};
    rd_data_a = {32'h0, 32'hDEAD_BEEF};
    rs_num_a  = {5'd7, 5'd5};
    expect_chk(0, 32'h0, "rst_rs0_bypass");
    expect_chk(1, 32'h0, "rst_rs1");
    expect_chk(3, 32'h0, "rst_valid");
    expect_chk(4, 32'h0, "rst_done");
    tick();
    rst = 1'b0;
    rd_we_a = 2'b00;
    expect_chk(0, 32'h0, "rst_write_discard");
    tick();
    rd_num_a  = {5'd5, 5'd5};
    rd_data_a = {32'hBBBB_0002, 32'hAAAA_0001};
    rd_we_a   = 2'b11;
    rs_num_a  = {5'd0, 5'd5};
    expect_chk(0, 32'hBBBB_0002, "byp_high_port");
    expect_chk(1, 32'h0, "r0_read");
    tick();
    rd_we_a = 2'b00;
    expect_chk(0, 32'hBBBB_0002, "store_high_port");
    tick();
    rd_num_a  = {5'd0, 5'd0};
    rd_data_a = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    rd_we_a   = 2'b11;
    rs_num_a  = {5'd0, 5'd0};
    expect_chk(0, 32'h0, "r0_byp_p0");
    expect_chk(1, 32'h0, "r0_byp_p1");
    tick();
    rd_we_a = 2'b00;
    expect_chk(0, 32'h0, "r0_after_p0");
    expect_chk(1, 32'h0, "r0_after_p1");
    tick();
    rd_num_a  = {5'd9, 5'd2};
    rd_data_a = {32'h0000_0909, 32'h0000_0202};
    rd_we_a   = 2'b11;
    rs_num_a  = {5'd9, 5'd2};
    expect_chk(0, 32'h0000_0202, "byp_port0");
    expect_chk(1, 32'h0000_0909, "byp_port1");
    tick();
    rd_we_a = 2'b00;
    expect_chk(0, 32'h0000_0202, "store_port0");
    expect_chk(1, 32'h0000_0909, "store_port1");
    tick();
    rd_num_b  = 5'd3;
    rd_data_b = 32'h1234;
    rd_we_b   = 1'b1;
    rs_num_b  = {5'd0, 5'd3};
    expect_chk(2, 32'h0, "nobyp_old");
    tick();
    rd_we_b = 1'b0;
    expect_chk(2, 32'h1234, "nobyp_new");
    tick();
    for (int i = 1; i < 32; i++) begin
      rd_num_a  = {5'(i), 5'd0};
      rd_data_a = {32'h100 + 32'(i), 32'h0000_FFFF};
      rd_we_a   = 2'b10;
      tick();
    end
    rd_we_a  = 2'b00;
    rs_num_a = {5'd31, 5'd7};
    expect_chk(0, 32'h107, "preload_r7");
    expect_chk(1, 32'h11F, "preload_r31");
    tick();
    push_dump(1'b0);
    halted_a = 1'b1;
    n = 0;
    while (done_cnt < 1 && n < 3000) begin
      dr_a = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (done_cnt < 1) begin
      err_cnt++;
      $display("FAIL dump1_timeout: got done=%0d expected 1", done_cnt);
    end
    for (int i = 0; i < 40; i++) begin
      dr_a = 1'($urandom_range(0, 1));
      tick();
    end
    chk_cnt++;
    if (done_cnt != 1 || beat_q.size() != 0) begin
      err_cnt++;
      $display("FAIL one_dump: got done=%0d left=%0d expected 1/0",
               done_cnt, beat_q.size());
    end
    halted_a = 1'b0;
    dr_a = 1'b1;
    tick();
    tick();
    tick();
    base = beat_cnt;
    push_dump(1'b0);
    halted_a = 1'b1;
    n = 0;
    while (beat_cnt < base + 10 && n < 200) begin
      tick();
      n++;
    end
    if (beat_cnt < base + 10) begin
      err_cnt++;
      $display("FAIL dump2_timeout: got beats=%0d expected %0d",
               beat_cnt - base, 10);
    end
    rst = 1'b1;
    beat_q.delete();
    rs_num_a = {5'd7, 5'd7};
    expect_chk(3, 32'h0, "mid_rst_valid");
    expect_chk(4, 32'h0, "mid_rst_done");
    expect_chk(5, 32'h0, "mid_rst_idx");
    expect_chk(6, 32'h0, "mid_rst_data");
    expect_chk(0, 32'h0, "mid_rst_rs0");
    expect_chk(1, 32'h0, "mid_rst_rs1");
    tick();
    push_dump(1'b1);
    rst = 1'b0;
    n = 0;
    while (done_cnt < 2 && n < 300) begin
      tick();
      n++;
    end
    if (done_cnt < 2) begin
      err_cnt++;
      $display("FAIL dump3_timeout: got done=%0d expected 2", done_cnt);
    end
    halted_a = 1'b0;
    tick();
    tick();
    chk_cnt++;
    if (beat_q.size() != 0 || done_cnt != 2) begin
      err_cnt++;
      $display("FAIL final: got left=%0d done=%0d expected 0/2",
               beat_q.size(), done_cnt);
    end
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
